// File: rtl/arashi_pkg.sv
// Shared types for the arashi thread tracker: per-thread state, completion opcodes
// and the thread-count derivation.
package arashi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    INFLIGHT = 2'd2,
    WAIT     = 2'd3
  } thread_state_e;

  typedef enum logic [1:0] {
    DONE  = 2'd0,
    RETRY = 2'd1,
    STALL = 2'd2,
    RSVD  = 2'd3
  } cmpl_op_e;

  function automatic int thread_num(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/arashi_thread_slot.sv
// One thread's state machine and optional stall countdown (ARASHI_TRACKER_STALL_EN).
// Hits arrive already decoded for this thread; err_o flags an illegal launch/completion this cycle.
module arashi_thread_slot
  import arashi_pkg::*;
#(
  parameter int STALL_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   launch_hit_i,
  input  logic                   grant_hit_i,
  input  logic                   cmpl_hit_i,
  input  cmpl_op_e               cmpl_op_i,
  input  logic [STALL_WIDTH-1:0] cmpl_stall_i,
  output logic                   avail_o,
  output logic                   busy_o,
  output logic                   err_o
);

  thread_state_e state_q;

`ifdef ARASHI_TRACKER_STALL_EN
  logic [STALL_WIDTH-1:0] cnt_q;
`else
  logic unused_stall;
  assign unused_stall = ^cmpl_stall_i;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
`ifdef ARASHI_TRACKER_STALL_EN
      cnt_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE:     if (launch_hit_i) state_q <= READY;
        READY:    if (grant_hit_i) state_q <= INFLIGHT;
        INFLIGHT: begin
          if (cmpl_hit_i) begin
            case (cmpl_op_i)
              RETRY: state_q <= READY;
              STALL: begin
`ifdef ARASHI_TRACKER_STALL_EN
                if (cmpl_stall_i == '0) begin
                  state_q <= READY;
                end else begin
                  state_q <= WAIT;
                  cnt_q   <= cmpl_stall_i;
                end
`else
                state_q <= READY;
`endif
              end
              default: state_q <= IDLE;
            endcase
          end
        end
`ifdef ARASHI_TRACKER_STALL_EN
        // Leaving on the count-of-one edge gives exactly N cycles in WAIT.
        WAIT: begin
          cnt_q <= cnt_q - STALL_WIDTH'(1);
          if (cnt_q == STALL_WIDTH'(1)) state_q <= READY;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avail_o = (state_q == READY);
  assign busy_o  = (state_q != IDLE);
  assign err_o   = (launch_hit_i && (state_q != IDLE)) ||
                   (cmpl_hit_i && (state_q != INFLIGHT));

endmodule

// File: rtl/arashi_thread_tracker.sv
// Per-thread tracker feeding the round-robin arbiter's avail vector and turning grants into
// issue pulses. Stall countdown support is enabled by defining ARASHI_TRACKER_STALL_EN.
module arashi_thread_tracker
  import arashi_pkg::*;
#(
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int STALL_WIDTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   launch_valid,
  input  logic [THREAD_NUM_WIDTH-1:0]            launch_id,
  output logic [thread_num(THREAD_NUM_WIDTH)-1:0] avail,
  input  logic                                   grant_ready,
  input  logic [THREAD_NUM_WIDTH-1:0]            grant_id,
  output logic                                   issue_valid,
  output logic [THREAD_NUM_WIDTH-1:0]            issue_id,
  input  logic                                   cmpl_valid,
  input  logic [THREAD_NUM_WIDTH-1:0]            cmpl_id,
  input  logic [1:0]                             cmpl_op,
  input  logic [STALL_WIDTH-1:0]                 cmpl_stall,
  output logic                                   busy,
  output logic                                   err
);

  localparam int THREAD_NUM = thread_num(THREAD_NUM_WIDTH);

  logic [THREAD_NUM-1:0]       avail_s;
  logic [THREAD_NUM-1:0]       busy_s;
  logic [THREAD_NUM-1:0]       err_s;
  logic                        issue_valid_q;
  logic [THREAD_NUM_WIDTH-1:0] issue_id_q;
  logic                        err_q;
  logic                        grant_hit;

  for (genvar i = 0; i < THREAD_NUM; i++) begin : g_slot
    arashi_thread_slot #(
      .STALL_WIDTH (STALL_WIDTH)
    ) u_slot (
      .clk          (clk),
      .rstn         (rstn),
      .launch_hit_i (launch_valid && (launch_id == THREAD_NUM_WIDTH'(i))),
      .grant_hit_i  (grant_ready && (grant_id == THREAD_NUM_WIDTH'(i))),
      .cmpl_hit_i   (cmpl_valid && (cmpl_id == THREAD_NUM_WIDTH'(i))),
      .cmpl_op_i    (cmpl_op_e'(cmpl_op)),
      .cmpl_stall_i (cmpl_stall),
      .avail_o      (avail_s[i]),
      .busy_o       (busy_s[i]),
      .err_o        (err_s[i])
    );
  end

  // Stale grants (thread no longer READY) are dropped without flagging an error.
  assign grant_hit = grant_ready && avail_s[grant_id];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      issue_valid_q <= grant_hit;
      if (grant_hit) issue_id_q <= grant_id;
      err_q         <= err_q | (|err_s);
    end
  end

  assign avail       = avail_s;
  assign busy        = |busy_s;
  assign issue_valid = issue_valid_q;
  assign issue_id    = issue_id_q;
  assign err         = err_q;

endmodule

// File: tb/tb_arashi_thread_tracker.sv
// Directed and randomized bench for arashi_thread_tracker against a cycle-numbered thread model.
module tb_arashi_thread_tracker;

  localparam int TN = 4;
  localparam int M_IDLE = 0, M_READY = 1, M_INFL = 2, M_WAIT = 3;

  logic       clk = 1'b0;
  logic       rstn;
  logic       launch_valid;
  logic [1:0] launch_id;
  logic [3:0] avail;
  logic       grant_ready;
  logic [1:0] grant_id;
  logic       issue_valid;
  logic [1:0] issue_id;
  logic       cmpl_valid;
  logic [1:0] cmpl_id;
  logic [1:0] cmpl_op;
  logic [3:0] cmpl_stall;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  int m_st[TN];
  int m_wake[TN];
  int ecount = 0;
  bit m_err, m_iv;
  int m_iid;

  arashi_thread_tracker #(
    .THREAD_NUM_WIDTH (2),
    .STALL_WIDTH      (4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .launch_valid (launch_valid),
    .launch_id    (launch_id),
    .avail        (avail),
    .grant_ready  (grant_ready),
    .grant_id     (grant_id),
    .issue_valid  (issue_valid),
    .issue_id     (issue_id),
    .cmpl_valid   (cmpl_valid),
    .cmpl_id      (cmpl_id),
    .cmpl_op      (cmpl_op),
    .cmpl_stall   (cmpl_stall),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [3:0] m_avail();
    logic [3:0] a;
    for (int i = 0; i < TN; i++) a[i] = (m_st[i] == M_READY);
    return a;
  endfunction

  function automatic logic m_busy();
    logic b = 1'b0;
    for (int i = 0; i < TN; i++) if (m_st[i] != M_IDLE) b = 1'b1;
    return b;
  endfunction

  // Model the effect of the upcoming clock edge from the current inputs.
  task automatic model_edge();
    int ns[TN];
    ecount++;
    if (!rstn) begin
      for (int i = 0; i < TN; i++) m_st[i] = M_IDLE;
      m_err = 0; m_iv = 0; m_iid = 0;
      return;
    end
    ns = m_st;
    m_iv = 0;
    if (grant_ready && m_st[grant_id] == M_READY) begin
      ns[grant_id] = M_INFL; m_iv = 1; m_iid = int'(grant_id);
    end
    if (launch_valid) begin
      if (m_st[launch_id] == M_IDLE) ns[launch_id] = M_READY;
      else m_err = 1;
    end
    if (cmpl_valid) begin
      if (m_st[cmpl_id] == M_INFL) begin
        if (cmpl_op == 2'b01) ns[cmpl_id] = M_READY;
        else if (cmpl_op == 2'b10) begin
`ifdef ARASHI_TRACKER_STALL_EN
          if (cmpl_stall == 0) ns[cmpl_id] = M_READY;
          else begin
            ns[cmpl_id] = M_WAIT;
            m_wake[cmpl_id] = ecount + int'(cmpl_stall);
          end
`else
          ns[cmpl_id] = M_READY;
`endif
        end else ns[cmpl_id] = M_IDLE;
      end else m_err = 1;
    end
    for (int i = 0; i < TN; i++)
      if (m_st[i] == M_WAIT && ecount == m_wake[i]) ns[i] = M_READY;
    m_st = ns;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    launch_valid = 0; launch_id = 0;
    grant_ready = 0; grant_id = 0;
    cmpl_valid = 0; cmpl_id = 0; cmpl_op = 0; cmpl_stall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    step();
    rstn = 1;
  endtask

  task automatic bring_inflight(input int id);
    idle_inputs();
    launch_valid = 1; launch_id = 2'(id);
    step();
    idle_inputs();
    grant_ready = 1; grant_id = 2'(id);
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    step();
    step();
    checks++; if (avail !== 4'b0000) begin errors++; $display("FAIL reset_avail got %b want 0000", avail); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b want 0", issue_valid); end
    checks++; if (issue_id !== 2'd0) begin errors++; $display("FAIL reset_issue_id got %0d want 0", issue_id); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    rstn = 1;
  endtask

  task automatic test_launch();
    idle_inputs();
    repeat (3) step();
    launch_valid = 1; launch_id = 2;
    step();
    idle_inputs();
    checks++; if (avail !== 4'b0100) begin errors++; $display("FAIL launch_avail got %b want 0100", avail); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL launch_busy got %b want 1", busy); end
  endtask

  task automatic test_grant();
    grant_ready = 1; grant_id = 2;
    step();
    checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL grant_issue_valid got %b want 1", issue_valid); end
    checks++; if (issue_id !== 2'd2) begin errors++; $display("FAIL grant_issue_id got %0d want 2", issue_id); end
    checks++; if (avail !== 4'b0000) begin errors++; $display("FAIL grant_avail got %b want 0000", avail); end
    step();
    idle_inputs();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL stale_grant_issue got %b want 0", issue_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stale_grant_err got %b want 0", err); end
  endtask

  task automatic test_complete();
    do_reset();
    for (int i = 0; i < TN; i++) bring_inflight(i);
    checks++; if (avail !== 4'b0000) begin errors++; $display("FAIL all_inflight_avail got %b want 0000", avail); end
    cmpl_valid = 1; cmpl_id = 0; cmpl_op = 2'b00;
    step();
    cmpl_valid = 1; cmpl_id = 1; cmpl_op = 2'b01;
    step();
    idle_inputs();
    checks++; if (avail !== 4'b0010) begin errors++; $display("FAIL done_retry_avail got %b want 0010", avail); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL done_retry_busy got %b want 1", busy); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL done_retry_err got %b want 0", err); end
    cmpl_valid = 1; cmpl_id = 2; cmpl_op = 2'b11;
    step();
    idle_inputs();
    checks++; if (avail !== 4'b0010) begin errors++; $display("FAIL rsvd_done_avail got %b want 0010", avail); end
  endtask

  task automatic test_stall();
    do_reset();
    bring_inflight(3);
    bring_inflight(2);
    cmpl_valid = 1; cmpl_id = 3; cmpl_op = 2'b10; cmpl_stall = 5;
    step();
    idle_inputs();
`ifdef ARASHI_TRACKER_STALL_EN
    checks++; if (avail[3] !== 1'b0) begin errors++; $display("FAIL stall_wait_0 got %b want 0", avail[3]); end
    for (int k = 1; k < 5; k++) begin
      step();
      checks++; if (avail[3] !== 1'b0) begin errors++; $display("FAIL stall_wait_%0d got %b want 0", k, avail[3]); end
    end
    step();
    checks++; if (avail[3] !== 1'b1) begin errors++; $display("FAIL stall_wake got %b want 1", avail[3]); end
`else
    checks++; if (avail[3] !== 1'b1) begin errors++; $display("FAIL stall_as_retry got %b want 1", avail[3]); end
`endif
    cmpl_valid = 1; cmpl_id = 2; cmpl_op = 2'b10; cmpl_stall = 0;
    step();
    idle_inputs();
    checks++; if (avail[2] !== 1'b1) begin errors++; $display("FAIL stall_zero got %b want 1", avail[2]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stall_err got %b want 0", err); end
  endtask

  task automatic test_err();
    do_reset();
    launch_valid = 1; launch_id = 1;
    step();
    launch_valid = 1; launch_id = 1;
    cmpl_valid = 1; cmpl_id = 0; cmpl_op = 2'b00;
    step();
    idle_inputs();
    checks++; if (avail !== 4'b0010) begin errors++; $display("FAIL err_avail got %b want 0010", avail); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err); end
    repeat (3) step();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_busy got %b want 1", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) bring_inflight(i);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_pre got %b want 1", busy); end
    grant_ready = 1; grant_id = 3;
    rstn = 0;
    step();
    idle_inputs();
    rstn = 1;
    checks++; if (avail !== 4'b0000) begin errors++; $display("FAIL mid_rst_avail got %b want 0000", avail); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_issue got %b want 0", issue_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got %b want 0", err); end
    cmpl_valid = 1; cmpl_id = 0; cmpl_op = 2'b00;
    step();
    idle_inputs();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL late_cmpl_err got %b want 1", err); end
  endtask

  task automatic test_random();
    int q[$];
    do_reset();
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      rstn = ((c % 97) != 96);
      if ($urandom_range(0, 9) < 4) begin
        q = {};
        for (int i = 0; i < TN; i++) if (m_st[i] == M_IDLE) q.push_back(i);
        launch_valid = 1;
        if (q.size() > 0 && $urandom_range(0, 9) < 9) launch_id = 2'(q[$urandom_range(0, q.size() - 1)]);
        else launch_id = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) < 6) begin
        q = {};
        for (int i = 0; i < TN; i++) if (m_st[i] == M_READY) q.push_back(i);
        grant_ready = 1;
        if (q.size() > 0 && $urandom_range(0, 3) != 0) grant_id = 2'(q[$urandom_range(0, q.size() - 1)]);
        else grant_id = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 9) < 5) begin
        q = {};
        for (int i = 0; i < TN; i++) if (m_st[i] == M_INFL) q.push_back(i);
        if (q.size() > 0) begin
          cmpl_valid = 1;
          cmpl_id = 2'(q[$urandom_range(0, q.size() - 1)]);
          cmpl_op = 2'($urandom_range(0, 3));
          cmpl_stall = 4'($urandom_range(0, 7));
        end else if ($urandom_range(0, 19) == 0) begin
          cmpl_valid = 1;
          cmpl_id = 2'($urandom_range(0, 3));
        end
      end
      step();
      checks++; if (avail !== m_avail()) begin errors++; $display("FAIL rand_avail c=%0d got %b want %b", c, avail, m_avail()); end
      checks++; if (busy !== m_busy()) begin errors++; $display("FAIL rand_busy c=%0d got %b want %b", c, busy, m_busy()); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err c=%0d got %b want %b", c, err, m_err); end
      checks++; if (issue_valid !== m_iv) begin errors++; $display("FAIL rand_issue_valid c=%0d got %b want %b", c, issue_valid, m_iv); end
      if (m_iv) begin
        checks++; if (issue_id !== 2'(m_iid)) begin errors++; $display("FAIL rand_issue_id c=%0d got %0d want %0d", c, issue_id, m_iid); end
      end
    end
    rstn = 1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < TN; i++) begin m_st[i] = M_IDLE; m_wake[i] = 0; end
    m_err = 0; m_iv = 0; m_iid = 0;
    idle_inputs();
    rstn = 0;
    test_reset();
    test_launch();
    test_grant();
    test_complete();
    test_stall();
    test_err();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
